// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the round-robin operand arbiter
package arb_pkg;

  localparam int NUM_REQ           = 4;
  localparam int SEL_W             = 2;
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - 4-way rotating priority picker (rotate, priority-encode, un-rotate)
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   winner
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_idx;

  // Rotate so that requester ptr lands at bit 0 and has highest priority.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[{1'b0, ptr} +: NUM_REQ];

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    w_idx = '0;
    if (w_rot[0])      w_idx = 2'd0;
    else if (w_rot[1]) w_idx = 2'd1;
    else if (w_rot[2]) w_idx = 2'd2;
    else if (w_rot[3]) w_idx = 2'd3;
  end

  assign found  = |req;
  assign winner = w_idx + ptr;

endmodule

// File: rtl/rr_operand_arbiter.sv
// rtl/rr_operand_arbiter.sv - round-robin burst arbiter for the shared operand bus; ARB_STATS_EN adds grant counters
module rr_operand_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
`ifdef ARB_STATS_EN
  output logic [63:0]        grant_cnt,
`endif
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t            r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic              w_busy;
  logic              w_req_sel;
  logic              w_last_sel;
  logic [DATA_W-1:0] w_data_sel;
  logic              w_accept;
  logic              w_release;
  logic [SEL_W-1:0]  w_next_ptr;
  logic [SEL_W-1:0]  w_pick_ptr;
  logic              w_found;
  logic [SEL_W-1:0]  w_winner;
  logic              w_load;

  assign w_busy     = (r_state == BUSY);
  assign w_req_sel  = req[r_sel];
  assign w_last_sel = last[r_sel];

  // Operand mux driven by the registered select.
  always_comb begin
    w_data_sel = '0;
    case (r_sel)
      2'd0:    w_data_sel = data0;
      2'd1:    w_data_sel = data1;
      2'd2:    w_data_sel = data2;
      default: w_data_sel = data3;
    endcase
  end

  assign out_valid = w_busy & w_req_sel;
  assign out_data  = w_busy ? w_data_sel : '0;
  assign busy      = w_busy;
  assign gnt       = r_gnt;
  assign sel       = r_sel;

  // A withdrawn request releases without moving a beat; otherwise release
  // only on an accepted final beat or when the burst cap is reached.
  assign w_accept   = out_valid & out_ready;
  assign w_release  = w_busy & (~w_req_sel |
                      (w_accept & (w_last_sel | (r_beat_cnt == LAST_BEAT))));
  assign w_next_ptr = r_sel + 2'd1;

  // On release the picker already sees the rotated pointer, so the next
  // owner is granted on the same edge with no idle bubble.
  assign w_pick_ptr = w_release ? w_next_ptr : r_ptr;
  assign w_load     = w_found & (~w_busy | w_release);

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (w_pick_ptr),
    .found  (w_found),
    .winner (w_winner)
  );

  // Grant FSM, round-robin pointer and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_release) r_ptr <= w_next_ptr;
      if (w_load) begin
        r_state    <= BUSY;
        r_gnt      <= NUM_REQ'(1) << w_winner;
        r_sel      <= w_winner;
        r_beat_cnt <= '0;
      end else if (w_release) begin
        r_state    <= IDLE;
        r_gnt      <= '0;
        r_sel      <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    // Saturating count of grant events won by requester gi.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_grant_cnt[gi] <= '0;
      end else if (w_load && (w_winner == SEL_W'(gi)) && (r_grant_cnt[gi] != 16'hFFFF)) begin
        r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
      end
    end
    assign grant_cnt[16*gi +: 16] = r_grant_cnt[gi];
  end
`endif

endmodule
